// File: rtl/multicycle_sequencer.sv
// Multicycle RV32I phase sequencer: steps FETCH/DECODE/EXECUTE/MEM/WRITEBACK, owns the
// shared memory port handshake, gates register-file writes and counts retired instructions.
module multicycle_sequencer #(
  parameter int unsigned INSTRET_W = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [6:0]           opcode,
  input  logic                 br_taken,
  input  logic                 mem_ready,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic                 mem_addr_sel,
  output logic                 ir_write,
  output logic                 pc_write,
  output logic                 pc_sel,
  output logic                 ru_write_en,
  output logic                 retire,
  output logic [INSTRET_W-1:0] instret,
  output logic                 illegal,
  output logic [2:0]           state
);

  typedef enum logic [2:0] {
    S_FETCH     = 3'd0,
    S_DECODE    = 3'd1,
    S_EXECUTE   = 3'd2,
    S_MEM       = 3'd3,
    S_WRITEBACK = 3'd4,
    S_TRAP      = 3'd7
  } state_t;

  typedef enum logic [2:0] {
    C_ALU     = 3'd0,
    C_LOAD    = 3'd1,
    C_STORE   = 3'd2,
    C_BRANCH  = 3'd3,
    C_JUMP    = 3'd4,
    C_ILLEGAL = 3'd7
  } iclass_t;

  state_t                 state_q;
  state_t                 state_d;
  iclass_t                class_q;
  iclass_t                class_d;
  logic [INSTRET_W-1:0]   instret_q;

  logic req_raw, we_raw, addr_sel_raw, ir_write_raw, pc_write_raw;
  logic pc_sel_raw, ru_write_raw, retire_raw, illegal_raw;

  // Opcode to instruction class; only consumed in DECODE.
  always_comb begin
    class_d = C_ILLEGAL;
    case (opcode)
      7'b0110011, 7'b0010011, 7'b0110111, 7'b0010111: class_d = C_ALU;
      7'b0000011:                                     class_d = C_LOAD;
      7'b0100011:                                     class_d = C_STORE;
      7'b1100011:                                     class_d = C_BRANCH;
      7'b1101111, 7'b1100111:                         class_d = C_JUMP;
      default:                                        class_d = C_ILLEGAL;
    endcase
  end

  // Next state and per-phase strobes; mem_ready/br_taken are only looked at where meaningful.
  always_comb begin
    state_d      = state_q;
    req_raw      = 1'b0;
    we_raw       = 1'b0;
    addr_sel_raw = 1'b0;
    ir_write_raw = 1'b0;
    pc_write_raw = 1'b0;
    pc_sel_raw   = 1'b0;
    ru_write_raw = 1'b0;
    retire_raw   = 1'b0;
    illegal_raw  = 1'b0;
    case (state_q)
      S_FETCH: begin
        req_raw = 1'b1;
        if (mem_ready) begin
          ir_write_raw = 1'b1;
          state_d      = S_DECODE;
        end
      end
      S_DECODE: begin
        state_d = (class_d == C_ILLEGAL) ? S_TRAP : S_EXECUTE;
      end
      S_EXECUTE: begin
        case (class_q)
          C_ALU, C_JUMP:   state_d = S_WRITEBACK;
          C_LOAD, C_STORE: state_d = S_MEM;
          C_BRANCH: begin
            pc_write_raw = 1'b1;
            pc_sel_raw   = br_taken;
            retire_raw   = 1'b1;
            state_d      = S_FETCH;
          end
          default:         state_d = S_TRAP;
        endcase
      end
      S_MEM: begin
        req_raw      = 1'b1;
        addr_sel_raw = 1'b1;
        we_raw       = (class_q == C_STORE);
        if (mem_ready) begin
          if (class_q == C_STORE) begin
            pc_write_raw = 1'b1;
            retire_raw   = 1'b1;
            state_d      = S_FETCH;
          end else begin
            state_d = S_WRITEBACK;
          end
        end
      end
      S_WRITEBACK: begin
        ru_write_raw = 1'b1;
        pc_write_raw = 1'b1;
        retire_raw   = 1'b1;
        pc_sel_raw   = (class_q == C_JUMP);
        state_d      = S_FETCH;
      end
      default: begin
        // TRAP and the unreachable codes 5/6 all park here until reset.
        illegal_raw = 1'b1;
        state_d     = S_TRAP;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_FETCH;
      class_q   <= C_ALU;
      instret_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_DECODE) class_q <= class_d;
      if (retire_raw) instret_q <= instret_q + INSTRET_W'(1);
    end
  end

  // Reset silences every output regardless of the register contents.
  assign mem_req      = ~rst & req_raw;
  assign mem_we       = ~rst & we_raw;
  assign mem_addr_sel = ~rst & addr_sel_raw;
  assign ir_write     = ~rst & ir_write_raw;
  assign pc_write     = ~rst & pc_write_raw;
  assign pc_sel       = ~rst & pc_sel_raw;
  assign ru_write_en  = ~rst & ru_write_raw;
  assign retire       = ~rst & retire_raw;
  assign illegal      = ~rst & illegal_raw;
  assign instret      = rst ? '0 : instret_q;
  assign state        = rst ? 3'd0 : state_q;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Directed bench for multicycle_sequencer: per-cycle expected state and strobe vectors.
module tb_multicycle_sequencer;

  logic        clk;
  logic        rst;
  logic [6:0]  opcode;
  logic        br_taken;
  logic        mem_ready;
  logic        mem_req, mem_we, mem_addr_sel, ir_write, pc_write, pc_sel;
  logic        ru_write_en, retire, illegal;
  logic [31:0] instret;
  logic [2:0]  state;

  int vectors;
  int miscompares;

  multicycle_sequencer #(.INSTRET_W(32)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .br_taken(br_taken), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr_sel(mem_addr_sel), .ir_write(ir_write),
    .pc_write(pc_write), .pc_sel(pc_sel), .ru_write_en(ru_write_en), .retire(retire),
    .instret(instret), .illegal(illegal), .state(state)
  );

  // {state, req, we, addr_sel, ir_write, pc_write, pc_sel, ru_write_en, retire, illegal}
  logic [11:0] obs;
  assign obs = {state, mem_req, mem_we, mem_addr_sel, ir_write, pc_write, pc_sel,
                ru_write_en, retire, illegal};

  localparam logic [11:0] ZERO  = 12'h000;
  localparam logic [11:0] FW    = {3'd0, 9'b100000000};
  localparam logic [11:0] FR    = {3'd0, 9'b100100000};
  localparam logic [11:0] DEC   = {3'd1, 9'b000000000};
  localparam logic [11:0] EX    = {3'd2, 9'b000000000};
  localparam logic [11:0] EXBT  = {3'd2, 9'b000011010};
  localparam logic [11:0] EXBN  = {3'd2, 9'b000010010};
  localparam logic [11:0] ML    = {3'd3, 9'b101000000};
  localparam logic [11:0] MSW   = {3'd3, 9'b111000000};
  localparam logic [11:0] MSR   = {3'd3, 9'b111010010};
  localparam logic [11:0] WBA   = {3'd4, 9'b000010110};
  localparam logic [11:0] WBJ   = {3'd4, 9'b000011110};
  localparam logic [11:0] TRAPV = {3'd7, 9'b000000001};

  localparam logic [6:0] OP_ADD  = 7'b0110011;
  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_BAD  = 7'b1111111;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic test_reset();
    rst = 1'b1; opcode = OP_ADD; br_taken = 1'b0; mem_ready = 1'b1;
    #1;
    vectors++;
    if (obs !== ZERO) begin
      miscompares++; $display("FAIL reset_outputs: got %h want %h", obs, ZERO);
    end
    @(posedge clk); #1;
    @(posedge clk); #1;
    #1;
    vectors++;
    if (obs !== ZERO || instret !== 32'd0) begin
      miscompares++; $display("FAIL reset_held: got %h/%h want %h/0", obs, instret, ZERO);
    end
    @(posedge clk); #1;
    rst = 1'b0; mem_ready = 1'b0;
    #2;
    vectors++;
    if (obs !== FW || instret !== 32'd0) begin
      miscompares++; $display("FAIL reset_release: got %h/%h want %h/0", obs, instret, FW);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_add();
    logic [11:0] exp [4] = '{FR, DEC, EX, WBA};
    for (int i = 0; i < 4; i++) begin
      opcode = OP_ADD; mem_ready = 1'b1; br_taken = 1'bx;
      #2;
      vectors++;
      if (obs !== exp[i]) begin
        miscompares++; $display("FAIL add_cyc%0d: got %h want %h", i, obs, exp[i]);
      end
      @(posedge clk); #1;
    end
    #2;
    vectors++;
    if (instret !== 32'd1) begin
      miscompares++; $display("FAIL add_instret: got %0d want 1", instret);
    end
  endtask

  task automatic test_load_wait();
    logic        mr  [11] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'bx, 1'bx, 1'b0, 1'b0, 1'b0, 1'b1, 1'bx};
    logic [11:0] exp [11] = '{FW, FW, FW, FR, DEC, EX, ML, ML, ML, ML, WBA};
    for (int i = 0; i < 11; i++) begin
      opcode = OP_LW; mem_ready = mr[i]; br_taken = 1'bx;
      #2;
      vectors++;
      if (obs !== exp[i]) begin
        miscompares++; $display("FAIL lw_cyc%0d: got %h want %h", i, obs, exp[i]);
      end
      @(posedge clk); #1;
    end
    #2;
    vectors++;
    if (instret !== 32'd2) begin
      miscompares++; $display("FAIL lw_instret: got %0d want 2", instret);
    end
  endtask

  task automatic test_store_branch();
    logic [6:0]  op  [11] = '{OP_SW, OP_SW, OP_SW, OP_SW, OP_SW,
                              OP_BEQ, OP_BEQ, OP_BEQ, OP_BEQ, OP_BEQ, OP_BEQ};
    logic        mr  [11] = '{1'b1, 1'bx, 1'bx, 1'b0, 1'b1, 1'b1, 1'bx, 1'bx, 1'b1, 1'bx, 1'bx};
    logic        br  [11] = '{1'bx, 1'bx, 1'bx, 1'bx, 1'bx, 1'bx, 1'bx, 1'b1, 1'bx, 1'bx, 1'b0};
    logic [11:0] exp [11] = '{FR, DEC, EX, MSW, MSR, FR, DEC, EXBT, FR, DEC, EXBN};
    for (int i = 0; i < 11; i++) begin
      opcode = op[i]; mem_ready = mr[i]; br_taken = br[i];
      #2;
      vectors++;
      if (obs !== exp[i]) begin
        miscompares++; $display("FAIL sw_beq_cyc%0d: got %h want %h", i, obs, exp[i]);
      end
      @(posedge clk); #1;
    end
    mem_ready = 1'b0;
    #2;
    vectors++;
    if (obs !== FW || instret !== 32'd5) begin
      miscompares++; $display("FAIL sw_beq_after: got %h/%0d want %h/5", obs, instret, FW);
    end
  endtask

  task automatic test_jump();
    logic [11:0] exp [4] = '{FR, DEC, EX, WBJ};
    for (int i = 0; i < 8; i++) begin
      opcode = (i < 4) ? OP_JAL : OP_JALR; mem_ready = (i % 4 == 0) ? 1'b1 : 1'bx;
      br_taken = 1'bx;
      #2;
      vectors++;
      if (obs !== exp[i % 4]) begin
        miscompares++; $display("FAIL jump_cyc%0d: got %h want %h", i, obs, exp[i % 4]);
      end
      @(posedge clk); #1;
    end
    #2;
    vectors++;
    if (instret !== 32'd7) begin
      miscompares++; $display("FAIL jump_instret: got %0d want 7", instret);
    end
  endtask

  task automatic test_illegal();
    logic [11:0] want;
    for (int i = 0; i < 22; i++) begin
      opcode = OP_BAD; br_taken = 1'(i >> 1);
      mem_ready = (i == 0) ? 1'b1 : 1'(i);
      want = (i == 0) ? FR : (i == 1) ? DEC : TRAPV;
      #2;
      vectors++;
      if (obs !== want) begin
        miscompares++; $display("FAIL illegal_cyc%0d: got %h want %h", i, obs, want);
      end
      @(posedge clk); #1;
    end
    rst = 1'b1;
    #2;
    vectors++;
    if (obs !== ZERO) begin
      miscompares++; $display("FAIL illegal_rst: got %h want %h", obs, ZERO);
    end
    @(posedge clk); #1;
    rst = 1'b0; mem_ready = 1'b0;
    #2;
    vectors++;
    if (obs !== FW || instret !== 32'd0) begin
      miscompares++; $display("FAIL illegal_exit: got %h/%0d want %h/0", obs, instret, FW);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_wrap();
    logic [11:0] exp [4] = '{FR, DEC, EX, WBA};
    force dut.instret_q = 32'hFFFF_FFFF;
    #1;
    release dut.instret_q;
    #1;
    vectors++;
    if (instret !== 32'hFFFF_FFFF) begin
      miscompares++; $display("FAIL wrap_preload: got %h want ffffffff", instret);
    end
    for (int i = 0; i < 4; i++) begin
      opcode = OP_ADD; mem_ready = 1'b1; br_taken = 1'bx;
      #1;
      vectors++;
      if (obs !== exp[i]) begin
        miscompares++; $display("FAIL wrap_cyc%0d: got %h want %h", i, obs, exp[i]);
      end
      @(posedge clk); #1;
    end
    #2;
    vectors++;
    if (instret !== 32'd0) begin
      miscompares++; $display("FAIL wrap_instret: got %h want 0", instret);
    end
  endtask

  task automatic test_rst_mid();
    logic        mr  [4] = '{1'b1, 1'bx, 1'bx, 1'b0};
    logic [11:0] exp [4] = '{FR, DEC, EX, ML};
    for (int i = 0; i < 4; i++) begin
      opcode = OP_LW; mem_ready = mr[i]; br_taken = 1'bx;
      #2;
      vectors++;
      if (obs !== exp[i]) begin
        miscompares++; $display("FAIL rst_mid_cyc%0d: got %h want %h", i, obs, exp[i]);
      end
      if (i < 3) begin
        @(posedge clk); #1;
      end
    end
    // Still in MEM: memory completes exactly as reset hits.
    rst = 1'b1; mem_ready = 1'b1;
    #1;
    vectors++;
    if (obs !== ZERO) begin
      miscompares++; $display("FAIL rst_mid_abort: got %h want %h", obs, ZERO);
    end
    @(posedge clk); #1;
    rst = 1'b0; mem_ready = 1'b0;
    #2;
    vectors++;
    if (obs !== FW || instret !== 32'd0) begin
      miscompares++; $display("FAIL rst_mid_after: got %h/%0d want %h/0", obs, instret, FW);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    rst = 1'b1; opcode = 7'd0; br_taken = 1'b0; mem_ready = 1'b0;
    #1;
    test_reset();
    test_add();
    test_load_wait();
    test_store_branch();
    test_jump();
    test_illegal();
    test_wrap();
    test_rst_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/multicycle_sequencer.md
# multicycle_sequencer

Finite-state sequencer that runs the RV32I datapath in multicycle mode. It sits beside `control_unit` and gates that unit's per-instruction decode into per-phase strobes: `ir_write`, `pc_write`, register-file write enable and memory requests. It owns the single shared instruction/data memory port through a req/ready handshake. It also counts retired instructions and traps on unsupported opcodes.

## Interface
Parameters:
- `INSTRET_W`, default 32: width of the retired-instruction counter.

Ports:
- `clk` input 1: single clock. All state changes on the rising edge.
- `rst` input 1: reset, synchronous, active-high.
- `opcode` input 7: `ir[6:0]`; sampled only in DECODE.
- `br_taken` input 1: branch-condition result; sampled only in EXECUTE for branches.
- `mem_ready` input 1: memory completes the current request this cycle.
- `mem_req` output 1: memory request, held until `mem_ready`.
- `mem_we` output 1: 1 = store access, 0 = read.
- `mem_addr_sel` output 1: 0 = PC (fetch), 1 = ALU result (load/store).
- `ir_write` output 1: load instruction register.
- `pc_write` output 1: update PC.
- `pc_sel` output 1: 0 = PC+4, 1 = ALU target.
- `ru_write_en` output 1: gates `control_unit.ru_write` into the register file.
- `retire` output 1: one-cycle pulse per completed instruction.
- `instret` output INSTRET_W: retired-instruction count.
- `illegal` output 1: sticky trap flag.
- `state` output 3: current state, for debug.

## Operation
- State encoding: FETCH=0, DECODE=1, EXECUTE=2, MEM=3, WRITEBACK=4, TRAP=7. Codes 5 and 6 are unreachable and map to TRAP.
- The class latch is a 3-bit register loaded in DECODE from `opcode`. Classes:
  - ALU: 0110011, 0010011, 0110111, 0010111
  - LOAD: 0000011
  - STORE: 0100011
  - BRANCH: 1100011
  - JUMP: 1101111, 1100111
  - Any other opcode is illegal.
- FETCH: `mem_req`=1, `mem_we`=0, `mem_addr_sel`=0. In the cycle `mem_ready`=1, `ir_write`=1 and next state is DECODE. Otherwise stay in FETCH.
- DECODE: latch the class. Legal opcode goes to EXECUTE; illegal goes to TRAP.
- EXECUTE:
  - ALU and JUMP go to WRITEBACK.
  - LOAD and STORE go to MEM.
  - BRANCH asserts `pc_write`=1, `pc_sel`=`br_taken` and `retire`=1, then goes to FETCH.
- MEM: `mem_req`=1, `mem_addr_sel`=1, `mem_we`=(class==STORE). Wait for `mem_ready`. Then:
  - LOAD goes to WRITEBACK.
  - STORE asserts `pc_write`=1, `pc_sel`=0 and `retire`=1 in the ready cycle, then goes to FETCH.
- WRITEBACK: `ru_write_en`=1, `pc_write`=1, `retire`=1, `pc_sel`=(class==JUMP). Next state is FETCH.
- TRAP: every strobe is 0, `illegal`=1, no memory requests. Only `rst` exits TRAP.
- `instret` increments by 1 on every `retire` cycle and wraps from 2^INSTRET_W−1 to 0.
- Each instruction produces exactly one `pc_write` and at most one `ru_write_en` cycle.

## Timing
- Strobe outputs are combinational from `state`, the class latch, `mem_ready` and `br_taken`. `state`, the class latch and `instret` are registered.
- While `rst`=1, every output is forced to 0.
- Cycle after reset release: `state`=FETCH, `mem_req`=1, `instret`=0, `illegal`=0. `rst` mid-instruction aborts it with no `retire` and no writes.
- Handshake rules:
  - `mem_req`, `mem_we` and `mem_addr_sel` stay stable from assertion until the cycle in which `mem_ready`=1.
  - Completion is the cycle where `mem_req` and `mem_ready` are both 1.
  - `mem_ready` while `mem_req`=0 (DECODE, EXECUTE, WRITEBACK, TRAP) is ignored.
  - Waits are unbounded; there is no timeout.
- Cycles per instruction with zero-wait memory (`mem_ready` tied 1): BRANCH 3; ALU, JUMP and STORE 4; LOAD 5. Each memory wait cycle adds 1.
- A store-to-fetch sequence is back to back: FETCH asserts `mem_req` the cycle after the store's ready cycle, with `mem_addr_sel` flipping from 1 to 0.
- `br_taken` and `mem_ready` are only meaningful in the states above. X on them elsewhere must not propagate to outputs.

## Test plan
- Reset then ADD (0110011) with `mem_ready`=1: states 0,1,2,4,0. `ir_write` in cycle 1, `ru_write_en`=`pc_write`=`retire`=1 in cycle 4, `pc_sel`=0, `instret`=1.
- LW with `mem_ready` held low 3 cycles in each of FETCH and MEM: `mem_req` continuously high across each wait with `mem_addr_sel` 0 then 1. Retire in cycle 11, `ru_write_en` only in WRITEBACK.
- SW followed by BEQ with `br_taken`=1, then BEQ with `br_taken`=0:
  - SW: `mem_we`=1 only in MEM, no `ru_write_en`, retires in MEM.
  - Branches: `pc_sel`=1 then 0 in EXECUTE, 3 cycles each.
- JAL and JALR: WRITEBACK with `ru_write_en`=1, `pc_sel`=1. `instret` advances by 2.
- Illegal opcode 1111111: TRAP from cycle 3, `illegal`=1, all strobes 0 for 20 cycles despite `mem_ready` toggling. `rst` returns to FETCH with `instret`=0.
- `instret` preloaded to 0xFFFFFFFF via force, one ADD: wraps to 0. `rst` asserted in MEM of a LW: no `retire`, no `ru_write_en`, next state FETCH.
